down_link_arb: RTL and testbench

- N-channel AXI-Stream frame arbiter on the 10G down-link path.
- Merges the per-channel MAC RX streams (already CDC'd into one domain) into one uplink stream.
- Round-robin, frame-atomic grant; link-status masking; oversize-frame truncation with error marking.
- Generalises the fixed 2-channel / 64-bit down-link to P_CHANNEL_NUM channels and P_DATA_WIDTH data.

---
 rtl/down_link_arb_pkg.sv | 22 ++
 rtl/down_link_arb_skid.sv | 60 ++++++
 rtl/down_link_arb.sv | 212 +++++++++++++++++++++
 tb/tb_down_link_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_link_arb_pkg.sv
// Shared constants for the down-link arbiter: FSM encodings, default widths
// and a constant-evaluable clog2 helper.
package down_link_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_XFER  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam int DEF_CHANNEL_NUM = 2;
   localparam int DEF_DATA_WIDTH  = 64;
   localparam int DEF_MAX_BEATS   = 1200;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/down_link_arb_skid.sv
// axis_skid_reg: two-entry AXI-Stream register slice. s_ready_o is a pure
// register output, so the upstream ready never depends on m_ready_i.
module axis_skid_reg #(
   parameter int P_WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               s_valid_i,
   output logic               s_ready_o,
   input  logic [P_WIDTH-1:0] s_data_i,
   output logic               m_valid_o,
   input  logic               m_ready_i,
   output logic [P_WIDTH-1:0] m_data_o
);

   logic               main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic [P_WIDTH-1:0] main_dat_q, main_dat_d, skid_dat_q, skid_dat_d;

   // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
   always_comb begin
      main_vld_d = main_vld_q;
      main_dat_d = main_dat_q;
      skid_vld_d = skid_vld_q;
      skid_dat_d = skid_dat_q;
      if (m_ready_i || !main_vld_q) begin
         if (skid_vld_q) begin
            main_vld_d = 1'b1;
            main_dat_d = skid_dat_q;
            skid_vld_d = 1'b0;
         end else begin
            main_vld_d = s_valid_i;
            if (s_valid_i) main_dat_d = s_data_i;
         end
      end else if (s_valid_i && !skid_vld_q) begin
         skid_vld_d = 1'b1;
         skid_dat_d = s_data_i;
      end
   end

   // NOTE: data registers are reset too, because the stream outputs must read 0 in reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_dat_q <= '0;
         skid_dat_q <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment only.
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_dat_q <= main_dat_d;
         skid_dat_q <= skid_dat_d;
      end
   end

   assign s_ready_o = !skid_vld_q;
   assign m_valid_o = main_vld_q;
   assign m_data_o  = main_dat_q;

endmodule

// File: rtl/down_link_arb.sv
// N-channel round-robin, frame-atomic AXI-Stream arbiter with link masking and
// oversize truncation. Define DOWN_LINK_ARB_STAT_EN for per-channel frame/error counters.
module down_link_arb
   import down_link_arb_pkg::*;
#(
   parameter int P_CHANNEL_NUM = DEF_CHANNEL_NUM,
   parameter int P_DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int P_KEEP_WIDTH  = P_DATA_WIDTH / 8,
   parameter int P_MAX_BEATS   = DEF_MAX_BEATS
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst,
   input  logic [P_CHANNEL_NUM-1:0]              i_link_up,
   input  logic [P_CHANNEL_NUM-1:0]              s_axis_tvalid,
   output logic [P_CHANNEL_NUM-1:0]              s_axis_tready,
   input  logic [P_CHANNEL_NUM*P_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [P_CHANNEL_NUM*P_KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [P_CHANNEL_NUM-1:0]              s_axis_tlast,
   input  logic [P_CHANNEL_NUM-1:0]              s_axis_tuser,
   output logic                                  m_axis_tvalid,
   input  logic                                  m_axis_tready,
   output logic [P_DATA_WIDTH-1:0]               m_axis_tdata,
   output logic [P_KEEP_WIDTH-1:0]               m_axis_tkeep,
   output logic                                  m_axis_tlast,
   output logic                                  m_axis_tuser,
`ifdef DOWN_LINK_ARB_STAT_EN
   output logic [P_CHANNEL_NUM*32-1:0]           o_frame_cnt,
   output logic [P_CHANNEL_NUM*32-1:0]           o_err_cnt,
`endif
   output logic [clog2(P_CHANNEL_NUM)-1:0]       o_grant_ch
);

   localparam int GW = clog2(P_CHANNEL_NUM);
   localparam int CW = clog2(P_MAX_BEATS + 1);
`ifdef DOWN_LINK_ARB_STAT_EN
   localparam int PW = GW + P_DATA_WIDTH + P_KEEP_WIDTH + 2;
`else
   localparam int PW = P_DATA_WIDTH + P_KEEP_WIDTH + 2;
`endif

   logic [1:0]               state_q, state_d;
   logic [GW-1:0]            grant_q, grant_d, ptr_q, ptr_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [P_CHANNEL_NUM-1:0] req, tready;
   logic [GW:0]              pick;
   logic                     g_link, g_valid, g_last, g_user;
   logic [P_DATA_WIDTH-1:0]  g_data, push_data;
   logic [P_KEEP_WIDTH-1:0]  g_keep, push_keep;
   logic                     push, push_last, push_user, skid_ready;
   logic [PW-1:0]            skid_in, skid_out;

   // First requester after ptr in circular order; MSB flags a valid pick.
   function automatic logic [GW:0] rr_pick(input logic [P_CHANNEL_NUM-1:0] r,
                                           input logic [GW-1:0] ptr);
      logic [GW:0] res;
      int          idx;
      res = '0;
      for (int i = P_CHANNEL_NUM; i >= 1; i--) begin
         idx = int'(ptr) + i;
         if (idx >= P_CHANNEL_NUM) idx = idx - P_CHANNEL_NUM;
         if (r[idx]) res = {1'b1, GW'(idx)};
      end
      return res;
   endfunction

   assign req     = s_axis_tvalid & i_link_up;
   assign pick    = rr_pick(req, ptr_q);
   assign g_link  = i_link_up[grant_q];
   assign g_valid = s_axis_tvalid[grant_q];
   assign g_last  = s_axis_tlast[grant_q];
   assign g_user  = s_axis_tuser[grant_q];
   assign g_data  = s_axis_tdata[grant_q*P_DATA_WIDTH +: P_DATA_WIDTH];
   assign g_keep  = s_axis_tkeep[grant_q*P_KEEP_WIDTH +: P_KEEP_WIDTH];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      push      = 1'b0;
      push_data = g_data;
      push_keep = g_keep;
      push_last = g_last;
      push_user = g_user;
      // Down channels drain freely unless they own the current frame.
      for (int c = 0; c < P_CHANNEL_NUM; c++) begin
         tready[c] = !i_link_up[c] && !(state_q != ST_IDLE && grant_q == GW'(c));
      end
      case (state_q)
         ST_IDLE: begin
            if (pick[GW]) begin
               grant_d = pick[GW-1:0];
               ptr_d   = pick[GW-1:0];
               cnt_d   = '0;
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            if (!g_link) begin
               if (skid_ready) begin
                  push      = 1'b1;
                  push_data = '0;
                  push_keep = P_KEEP_WIDTH'(1);
                  push_last = 1'b1;
                  push_user = 1'b1;
                  cnt_d     = '0;
                  state_d   = ST_FLUSH;
               end
            end else begin
               tready[grant_q] = skid_ready;
               if (skid_ready && g_valid) begin
                  push = 1'b1;
                  if (g_last) begin
                     cnt_d   = '0;
                     state_d = ST_IDLE;
                  end else if (cnt_q == CW'(P_MAX_BEATS - 1)) begin
                     push_last = 1'b1;
                     push_user = 1'b1;
                     cnt_d     = '0;
                     state_d   = ST_FLUSH;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
         ST_FLUSH: begin
            tready[grant_q] = 1'b1;
            if (!g_link || (g_valid && g_last)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= GW'(P_CHANNEL_NUM - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign s_axis_tready = i_rst ? '0 : tready;
   assign o_grant_ch    = grant_q;

`ifdef DOWN_LINK_ARB_STAT_EN
   logic [GW-1:0] out_ch;
   assign skid_in = {grant_q, push_data, push_keep, push_last, push_user};
   assign {out_ch, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;
`else
   assign skid_in = {push_data, push_keep, push_last, push_user};
   assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = skid_out;
`endif

   axis_skid_reg #(.P_WIDTH(PW)) u_skid (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .s_valid_i (push),
      .s_ready_o (skid_ready),
      .s_data_i  (skid_in),
      .m_valid_o (m_axis_tvalid),
      .m_ready_i (m_axis_tready),
      .m_data_o  (skid_out)
   );

`ifdef DOWN_LINK_ARB_STAT_EN
   logic                        upd_q, upd_d, upd_err_q, upd_err_d;
   logic [GW-1:0]               upd_ch_q, upd_ch_d;
   logic [P_CHANNEL_NUM*32-1:0] frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;

   // Counters follow the tlast handshake by one cycle and saturate at all-ones.
   always_comb begin
      upd_d       = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      upd_err_d   = m_axis_tuser;
      upd_ch_d    = out_ch;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (upd_q) begin
         if (frame_cnt_q[upd_ch_q*32 +: 32] != '1)
            frame_cnt_d[upd_ch_q*32 +: 32] = frame_cnt_q[upd_ch_q*32 +: 32] + 32'd1;
         if (upd_err_q && err_cnt_q[upd_ch_q*32 +: 32] != '1)
            err_cnt_d[upd_ch_q*32 +: 32] = err_cnt_q[upd_ch_q*32 +: 32] + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         upd_q       <= 1'b0;
         upd_err_q   <= 1'b0;
         upd_ch_q    <= '0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         upd_q       <= upd_d;
         upd_err_q   <= upd_err_d;
         upd_ch_q    <= upd_ch_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign o_frame_cnt = frame_cnt_q;
   assign o_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_down_link_arb.sv
// Directed self-checking bench for down_link_arb (3 channels, 64-bit, 1200-beat limit).
`timescale 1ns/1ps
module tb_down_link_arb;

   localparam int N    = 3;
   localparam int W    = 64;
   localparam int K    = 8;
   localparam int MAXB = 1200;

   typedef struct packed {
      logic [W-1:0] data;
      logic [K-1:0] keep;
      logic         last;
      logic         user;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   link_up, s_tvalid, s_tready, s_tlast, s_tuser;
   logic [N*W-1:0] s_tdata;
   logic [N*K-1:0] s_tkeep;
   logic           m_tvalid, m_tready, m_tlast, m_tuser;
   logic [W-1:0]   m_tdata;
   logic [K-1:0]   m_tkeep;
   logic [1:0]     grant;
`ifdef DOWN_LINK_ARB_STAT_EN
   logic [N*32-1:0] frame_cnt, err_cnt;
`endif

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   beat_t src_q[N][$];
   beat_t exp_q[N][$];
   beat_t out_q[$];
   int    out_cyc[$];
   int    pop_cnt[N];
   int    drop_after[N];
   bit    hs[N];
   bit    rand_rdy = 1'b0;
   bit    stall_prev = 1'b0;
   beat_t prev_beat;

   down_link_arb #(
      .P_CHANNEL_NUM (N),
      .P_DATA_WIDTH  (W),
      .P_KEEP_WIDTH  (K),
      .P_MAX_BEATS   (MAXB)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_link_up     (link_up),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tlast  (s_tlast),
      .s_axis_tuser  (s_tuser),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tkeep  (m_tkeep),
      .m_axis_tlast  (m_tlast),
      .m_axis_tuser  (m_tuser),
`ifdef DOWN_LINK_ARB_STAT_EN
      .o_frame_cnt   (frame_cnt),
      .o_err_cnt     (err_cnt),
`endif
      .o_grant_ch    (grant)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   // Sources, output sink and output-stability monitor; all act on the falling edge.
   initial begin
      s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; s_tuser = '0;
      m_tready = 1'b0;
      for (int c = 0; c < N; c++) begin
         hs[c] = 1'b0; pop_cnt[c] = 0; drop_after[c] = -1;
      end
      forever begin
         @(negedge clk);
         for (int c = 0; c < N; c++) begin
            if (hs[c]) begin
               void'(src_q[c].pop_front());
               pop_cnt[c]++;
               if (pop_cnt[c] == drop_after[c]) link_up[c] = 1'b0;
            end
            if (src_q[c].size() > 0) begin
               s_tvalid[c]         = 1'b1;
               s_tdata[c*W +: W]   = src_q[c][0].data;
               s_tkeep[c*K +: K]   = src_q[c][0].keep;
               s_tlast[c]          = src_q[c][0].last;
               s_tuser[c]          = src_q[c][0].user;
            end else begin
               s_tvalid[c] = 1'b0;
               s_tlast[c]  = 1'b0;
               s_tuser[c]  = 1'b0;
            end
         end
         m_tready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
         #1;
         for (int c = 0; c < N; c++) hs[c] = s_tvalid[c] & s_tready[c];
         if (stall_prev && !rst) begin
            total++;
            if (!m_tvalid || {m_tdata, m_tkeep, m_tlast, m_tuser} !== prev_beat) begin
               bad++;
               $display("FAIL stall_stable: got v=%0b %h want v=1 %h", m_tvalid,
                        {m_tdata, m_tkeep, m_tlast, m_tuser}, prev_beat);
            end
         end
         stall_prev = m_tvalid & !m_tready;
         prev_beat  = {m_tdata, m_tkeep, m_tlast, m_tuser};
         if (m_tvalid && m_tready) begin
            out_q.push_back({m_tdata, m_tkeep, m_tlast, m_tuser});
            out_cyc.push_back(cyc);
         end
      end
   end

   task automatic add_frame(input int c, input int f, input int n, input bit user);
      for (int b = 0; b < n; b++) begin
         beat_t bt;
         bt.data = {8'(c), 16'(f), 16'(b), 24'h0};
         bt.last = (b == n - 1);
         bt.keep = bt.last ? K'(8'hFF >> (f % 8)) : 8'hFF;
         bt.user = bt.last & user;
         src_q[c].push_back(bt);
         exp_q[c].push_back(bt);
      end
   endtask

   task automatic wait_out(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc && !ok; i++) begin
         @(negedge clk); #2;
         if (out_q.size() >= n) ok = 1'b1;
      end
   endtask

   task automatic start_test();
      @(negedge clk); #2;
      out_q.delete(); out_cyc.delete();
      for (int c = 0; c < N; c++) exp_q[c].delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; link_up = '1;
      repeat (3) @(negedge clk);
      #2;
      total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
      total++; if (m_tdata !== '0) begin bad++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
      total++; if ({m_tkeep, m_tlast, m_tuser} !== '0) begin bad++; $display("FAIL rst_ctl: got %h want 0", {m_tkeep, m_tlast, m_tuser}); end
      total++; if (s_tready !== '0) begin bad++; $display("FAIL rst_tready: got %b want 000", s_tready); end
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL rst_grant: got %0d want 0", grant); end
      rst = 1'b0;
      @(negedge clk); #2;
      total++; if (s_tready !== 3'b000) begin bad++; $display("FAIL idle_tready: got %b want 000", s_tready); end
      link_up[2] = 1'b0;
      #1;
      total++; if (s_tready !== 3'b100) begin bad++; $display("FAIL down_tready: got %b want 100", s_tready); end
      link_up[2] = 1'b1;
   endtask

   task automatic test_two_frames();
      beat_t exp[$];
      bit    ok;
      int    t0;
      start_test();
      add_frame(0, 1, 8, 1'b0);
      add_frame(1, 1, 8, 1'b0);
      t0  = cyc + 1;
      exp = {exp_q[0], exp_q[1]};
      wait_out(16, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL two_timeout: got %0d beats want 16", out_q.size()); end
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         total++;
         if (out_q[i] !== exp[i]) begin bad++; $display("FAIL two_beat%0d: got %h want %h", i, out_q[i], exp[i]); end
      end
      if (ok) begin
         total++; if (out_cyc[0] !== t0 + 2) begin bad++; $display("FAIL first_latency: got cyc %0d want %0d", out_cyc[0], t0 + 2); end
         total++; if (out_cyc[7] !== out_cyc[0] + 7) begin bad++; $display("FAIL ch0_contig: got %0d want %0d", out_cyc[7], out_cyc[0] + 7); end
         total++; if (out_cyc[8] !== out_cyc[7] + 2) begin bad++; $display("FAIL frame_gap: got %0d want %0d", out_cyc[8], out_cyc[7] + 2); end
         total++; if (out_cyc[15] !== out_cyc[8] + 7) begin bad++; $display("FAIL ch1_contig: got %0d want %0d", out_cyc[15], out_cyc[8] + 7); end
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int seq[$];
      int cnt0, cnt1, viol;
      start_test();
      for (int f = 0; f < 50; f++) begin
         add_frame(0, f, 2, 1'b0);
         add_frame(1, f, 2, 1'b0);
      end
      wait_out(200, 2000, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_timeout: got %0d beats want 200", out_q.size()); end
      cnt0 = 0; cnt1 = 0; viol = 0;
      foreach (out_q[i]) if (out_q[i].last) seq.push_back(int'(out_q[i].data[63:56]));
      foreach (seq[i]) begin
         if (seq[i] == 0) cnt0++;
         if (seq[i] == 1) cnt1++;
         if (i > 0 && seq[i] == seq[i-1]) viol++;
      end
      total++; if (viol != 0) begin bad++; $display("FAIL rr_alternate: got %0d repeats want 0", viol); end
      total++; if (cnt0 != 50 || cnt1 != 50) begin bad++; $display("FAIL rr_counts: got %0d/%0d want 50/50", cnt0, cnt1); end
      total++; if (seq.size() == 0 || seq[0] != 0) begin bad++; $display("FAIL rr_first: got first frame from other channel want ch0"); end
   endtask

   task automatic test_oversize();
      bit    ok;
      beat_t exp[$];
      beat_t bt;
      int    i;
      start_test();
      // The long frame carries tlast on its final (1300th) beat so the flush can end.
      add_frame(1, 7, 1300, 1'b0);
      for (i = 0; i < 5000 && src_q[1].size() > 0; i++) @(negedge clk);
      #2;
      total++; if (src_q[1].size() != 0) begin bad++; $display("FAIL os_drain: got %0d left want 0", src_q[1].size()); end
      add_frame(0, 8, 4, 1'b0);
      for (int b = 0; b < MAXB; b++) exp.push_back(exp_q[1][b]);
      exp[MAXB-1].last = 1'b1;
      exp[MAXB-1].user = 1'b1;
      foreach (exp_q[0][b]) exp.push_back(exp_q[0][b]);
      wait_out(MAXB + 4, 200, ok);
      repeat (10) @(negedge clk);
      #2;
      total++; if (out_q.size() != MAXB + 4) begin bad++; $display("FAIL os_count: got %0d want %0d", out_q.size(), MAXB + 4); end
      for (int b = 0; b < MAXB + 4 && b < out_q.size(); b++) begin
         total++;
         if (out_q[b] !== exp[b]) begin bad++; bt = exp[b]; $display("FAIL os_beat%0d: got %h want %h", b, out_q[b], bt); end
      end
   endtask

   task automatic test_link_drop();
      bit    ok;
      beat_t term;
      start_test();
      term = '{data: '0, keep: K'(1), last: 1'b1, user: 1'b1};
      pop_cnt[0] = 0; drop_after[0] = 4;
      add_frame(0, 3, 10, 1'b0);
      wait_out(5, 200, ok);
      repeat (20) @(negedge clk);
      #2;
      total++; if (out_q.size() != 5) begin bad++; $display("FAIL ld_count: got %0d want 5", out_q.size()); end
      for (int b = 0; b < 4 && b < out_q.size(); b++) begin
         total++; if (out_q[b] !== exp_q[0][b]) begin bad++; $display("FAIL ld_beat%0d: got %h want %h", b, out_q[b], exp_q[0][b]); end
      end
      total++; if (out_q.size() < 5 || out_q[4] !== term) begin bad++; $display("FAIL ld_term: got %0d beats want term %h last", out_q.size(), term); end
      total++; if (src_q[0].size() != 0) begin bad++; $display("FAIL ld_drain: got %0d left want 0", src_q[0].size()); end
      total++; if (s_tready[0] !== 1'b1) begin bad++; $display("FAIL ld_tready: got %b want 1", s_tready[0]); end
      drop_after[0] = -1;
      start_test();
      add_frame(1, 4, 3, 1'b0);
      add_frame(0, 4, 3, 1'b0);
      repeat (40) @(negedge clk);
      #2;
      total++; if (out_q.size() != 3) begin bad++; $display("FAIL ld_excl_count: got %0d want 3", out_q.size()); end
      for (int b = 0; b < 3 && b < out_q.size(); b++) begin
         total++; if (out_q[b] !== exp_q[1][b]) begin bad++; $display("FAIL ld_excl%0d: got %h want %h", b, out_q[b], exp_q[1][b]); end
      end
      total++; if (src_q[0].size() != 0) begin bad++; $display("FAIL ld_stale: got %0d left want 0", src_q[0].size()); end
      link_up[0] = 1'b1;
      start_test();
      add_frame(0, 5, 3, 1'b1);
      wait_out(3, 200, ok);
      total++; if (!ok) begin bad++; $display("FAIL ld_return: got %0d beats want 3", out_q.size()); end
      for (int b = 0; b < 3 && b < out_q.size(); b++) begin
         total++; if (out_q[b] !== exp_q[0][b]) begin bad++; $display("FAIL ld_ret%0d: got %h want %h", b, out_q[b], exp_q[0][b]); end
      end
   endtask

   task automatic test_backpressure();
      bit    ok;
      int    nb;
      int    ch;
      beat_t e;
      start_test();
      rand_rdy = 1'b1;
      nb = 0;
      for (int c = 0; c < N; c++) begin
         for (int f = 0; f < 4; f++) begin
            add_frame(c, 20 + f, 1 + (c * 3 + f * 2) % 6, f == 2);
            nb += 1 + (c * 3 + f * 2) % 6;
         end
      end
      wait_out(nb, 4000, ok);
      rand_rdy = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      total++; if (out_q.size() != nb) begin bad++; $display("FAIL bp_count: got %0d want %0d", out_q.size(), nb); end
      foreach (out_q[i]) begin
         ch = int'(out_q[i].data[63:56]);
         total++;
         if (ch >= N || exp_q[ch].size() == 0) begin
            bad++; $display("FAIL bp_unexpected%0d: got %h want no beat", i, out_q[i]);
         end else begin
            e = exp_q[ch].pop_front();
            if (out_q[i] !== e) begin bad++; $display("FAIL bp_beat%0d: got %h want %h", i, out_q[i], e); end
         end
      end
      for (int c = 0; c < N; c++) begin
         total++; if (exp_q[c].size() != 0) begin bad++; $display("FAIL bp_missing ch%0d: got %0d left want 0", c, exp_q[c].size()); end
      end
   endtask

`ifdef DOWN_LINK_ARB_STAT_EN
   task automatic test_stats();
      bit ok;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #2;
      total++; if (frame_cnt !== '0 || err_cnt !== '0) begin bad++; $display("FAIL st_reset: got %h/%h want 0", frame_cnt, err_cnt); end
      rst = 1'b0;
      start_test();
      for (int f = 0; f < 7; f++) add_frame(2, 40 + f, 3, f == 2 || f == 5);
      wait_out(21, 500, ok);
      repeat (4) @(negedge clk);
      #2;
      total++; if (frame_cnt[64 +: 32] !== 32'd7) begin bad++; $display("FAIL st_frames: got %0d want 7", frame_cnt[64 +: 32]); end
      total++; if (err_cnt[64 +: 32] !== 32'd2) begin bad++; $display("FAIL st_errs: got %0d want 2", err_cnt[64 +: 32]); end
      total++; if (frame_cnt[31:0] !== 32'd0) begin bad++; $display("FAIL st_ch0: got %0d want 0", frame_cnt[31:0]); end
   endtask
`endif

   initial begin
      rst = 1'b1;
      link_up = '1;
      test_reset();
      test_two_frames();
      test_round_robin();
      test_oversize();
      test_link_drop();
      test_backpressure();
`ifdef DOWN_LINK_ARB_STAT_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
